// File: rtl/ifetch_unit.sv
`timescale 1ns/1ps
// ifetch_unit: instruction fetch with a set-associative I-cache (round-robin
// replacement per set), a bimodal 2-bit BHT and a decoupling output queue.
// One line fill may be outstanding; it always completes, even across a redirect.
module ifetch_unit #(
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       WAYS        = 2,
   parameter int unsigned       SETS        = 16,
   parameter int unsigned       BLK_WORDS   = 16,
   parameter int unsigned       BHT_ENTRIES = 256,
   parameter int unsigned       QUEUE_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rdy,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_inst,
   output logic [ADDR_W-1:0]      out_pc,
   output logic                   out_pred_jump,
   output logic [ADDR_W-1:0]      out_pred_pc,
   output logic                   mc_en,
   output logic [ADDR_W-1:0]      mc_pc,
   input  logic                   mc_done,
   input  logic [32*BLK_WORDS-1:0] mc_data,
   input  logic                   rob_set_pc_en,
   input  logic [ADDR_W-1:0]      rob_set_pc,
   input  logic                   rob_br,
   input  logic                   rob_br_jump,
   input  logic [ADDR_W-1:0]      rob_br_pc
);

   localparam int unsigned WORD_W = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
   localparam int unsigned OFF_W  = $clog2(BLK_WORDS) + 2;
   localparam int unsigned IDX_W  = $clog2(SETS);
   localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;
   localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int unsigned BHT_W  = $clog2(BHT_ENTRIES);
   localparam int unsigned QP_W   = $clog2(QUEUE_DEPTH);
   localparam int unsigned QC_W   = QP_W + 1;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic {
      IDLE,
      WAIT_MEM
   } state_t;

   state_t state, state_nxt;

   // architectural fetch state
   logic [ADDR_W-1:0] pc;
   logic              mc_en_nxt;
   logic [ADDR_W-1:0] mc_pc_nxt;
   logic              fill_we;

   // cache arrays
   logic [SETS-1:0]   valid    [WAYS];
   logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
   logic [31:0]       data_mem [WAYS][SETS][BLK_WORDS];
   logic [WAY_W-1:0]  rr       [SETS];

   // branch history
   logic [1:0]        bht [BHT_ENTRIES];

   // output queue
   logic [31:0]       q_inst [QUEUE_DEPTH];
   logic [ADDR_W-1:0] q_pc   [QUEUE_DEPTH];
   logic              q_jump [QUEUE_DEPTH];
   logic [ADDR_W-1:0] q_pred [QUEUE_DEPTH];
   logic [QP_W-1:0]   q_head, q_tail;
   logic [QC_W-1:0]   q_count;

   // lookup / prediction signals
   logic [TAG_W-1:0]  pc_tag;
   logic [IDX_W-1:0]  pc_idx;
   logic [WORD_W-1:0] word_sel;
   logic              hit;
   logic [31:0]       hit_word;
   logic              pred_jump;
   logic [ADDR_W-1:0] pred_pc;
   logic [20:0]       jimm;
   logic [12:0]       bimm;
   logic [BHT_W-1:0]  bht_rd_idx, bht_wr_idx;

   // fill signals
   logic [TAG_W-1:0]  fill_tag;
   logic [IDX_W-1:0]  fill_idx;
   logic [WAY_W-1:0]  victim;
   logic              victim_found;
   logic [WAY_W-1:0]  rr_nxt;

   logic              q_full, push, pop;
   logic              unused_bits;

   assign pc_tag     = pc[ADDR_W-1 -: TAG_W];
   assign pc_idx     = pc[OFF_W +: IDX_W];
   assign fill_tag   = mc_pc[ADDR_W-1 -: TAG_W];
   assign fill_idx   = mc_pc[OFF_W +: IDX_W];
   assign bht_rd_idx = pc[BHT_W+1:2];
   assign bht_wr_idx = rob_br_pc[BHT_W+1:2];
   assign unused_bits = ^{rob_br_pc[ADDR_W-1:BHT_W+2], rob_br_pc[1:0]};

   if (BLK_WORDS > 1) begin : g_wsel
      assign word_sel = pc[OFF_W-1:2];
   end else begin : g_wsel_single
      assign word_sel = '0;
   end

   assign q_full = (q_count == QC_W'(QUEUE_DEPTH));
   assign push   = hit && !q_full && !rob_set_pc_en;
   assign pop    = (q_count != '0) && out_ready;

   assign out_valid     = (q_count != '0);
   assign out_inst      = q_inst[q_head];
   assign out_pc        = q_pc[q_head];
   assign out_pred_jump = q_jump[q_head];
   assign out_pred_pc   = q_pred[q_head];

   // tag compare across all ways; the fill rule keeps hits one-hot
   always_comb begin
      hit      = 1'b0;
      hit_word = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (valid[WAY_W'(w)][pc_idx] && (tag_mem[WAY_W'(w)][pc_idx] == pc_tag)) begin
            hit      = 1'b1;
            hit_word = data_mem[WAY_W'(w)][pc_idx][word_sel];
         end
      end
   end

   assign jimm = {hit_word[31], hit_word[19:12], hit_word[20], hit_word[30:21], 1'b0};
   assign bimm = {hit_word[31], hit_word[7], hit_word[30:25], hit_word[11:8], 1'b0};

   // next-PC prediction from the hit word
   always_comb begin
      pred_jump = 1'b0;
      pred_pc   = pc + ADDR_W'(4);
      case (hit_word[6:0])
         OP_JAL: begin
            pred_jump = 1'b1;
            pred_pc   = pc + {{(ADDR_W-21){jimm[20]}}, jimm};
         end
         OP_BRANCH: begin
            if (bht[bht_rd_idx][1]) begin
               pred_jump = 1'b1;
               pred_pc   = pc + {{(ADDR_W-13){bimm[12]}}, bimm};
            end
         end
         default: ;
      endcase
   end

   // victim: lowest invalid way in the fill set, else its round-robin pointer
   always_comb begin
      victim       = rr[fill_idx];
      victim_found = 1'b0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (!victim_found && !valid[WAY_W'(w)][fill_idx]) begin
            victim       = WAY_W'(w);
            victim_found = 1'b1;
         end
      end
      rr_nxt = (rr[fill_idx] == WAY_W'(WAYS-1)) ? '0 : rr[fill_idx] + 1'b1;
   end

   // fill FSM next state; redirects do not disturb an outstanding fill
   always_comb begin
      state_nxt = state;
      mc_en_nxt = mc_en;
      mc_pc_nxt = mc_pc;
      fill_we   = 1'b0;
      case (state)
         IDLE: begin
            if (!hit) begin
               mc_en_nxt = 1'b1;
               mc_pc_nxt = {pc_tag, pc_idx, {OFF_W{1'b0}}};
               state_nxt = WAIT_MEM;
            end
         end
         WAIT_MEM: begin
            if (mc_done) begin
               fill_we   = 1'b1;
               mc_en_nxt = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // control state: FSM, PC, valid/RR, BHT and queue pointers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         mc_en   <= 1'b0;
         mc_pc   <= '0;
         pc      <= RESET_PC;
         q_head  <= '0;
         q_tail  <= '0;
         q_count <= '0;
         for (int unsigned w = 0; w < WAYS; w++) begin
            valid[WAY_W'(w)] <= '0;
         end
         for (int unsigned s = 0; s < SETS; s++) begin
            rr[IDX_W'(s)] <= '0;
         end
         for (int unsigned b = 0; b < BHT_ENTRIES; b++) begin
            bht[BHT_W'(b)] <= 2'd0;
         end
      end else if (rdy) begin
         state <= state_nxt;
         mc_en <= mc_en_nxt;
         mc_pc <= mc_pc_nxt;
         if (fill_we) begin
            valid[victim][fill_idx] <= 1'b1;
            rr[fill_idx]            <= rr_nxt;
         end
         if (rob_br) begin
            if (rob_br_jump && (bht[bht_wr_idx] != 2'd3)) begin
               bht[bht_wr_idx] <= bht[bht_wr_idx] + 2'd1;
            end else if (!rob_br_jump && (bht[bht_wr_idx] != 2'd0)) begin
               bht[bht_wr_idx] <= bht[bht_wr_idx] - 2'd1;
            end
         end
         if (rob_set_pc_en) begin
            pc      <= rob_set_pc;
            q_head  <= '0;
            q_tail  <= '0;
            q_count <= '0;
         end else begin
            if (push) begin
               pc     <= pred_pc;
               q_tail <= q_tail + 1'b1;
            end
            if (pop) begin
               q_head <= q_head + 1'b1;
            end
            if (push && !pop) begin
               q_count <= q_count + 1'b1;
            end else if (!push && pop) begin
               q_count <= q_count - 1'b1;
            end
         end
      end
   end

   // storage without reset: line data, tags and queue payload
   always_ff @(posedge clk) begin
      if (rst && rdy) begin
         if (fill_we) begin
            tag_mem[victim][fill_idx] <= fill_tag;
            for (int unsigned i = 0; i < BLK_WORDS; i++) begin
               data_mem[victim][fill_idx][WORD_W'(i)] <= mc_data[32*i +: 32];
            end
         end
         if (push) begin
            q_inst[q_tail] <= hit_word;
            q_pc[q_tail]   <= pc;
            q_jump[q_tail] <= pred_jump;
            q_pred[q_tail] <= pred_pc;
         end
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
`timescale 1ns/1ps
// tb_ifetch_unit: scoreboard bench for ifetch_unit with a small memory
// controller model and per-scenario test tasks.
module tb_ifetch_unit;

   localparam int BLK_WORDS = 16;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        jump;
      logic [31:0] ppc;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic                   rdy = 1'b1;
   logic                   out_valid;
   logic                   out_ready = 1'b0;
   logic [31:0]            out_inst;
   logic [31:0]            out_pc;
   logic                   out_pred_jump;
   logic [31:0]            out_pred_pc;
   logic                   mc_en;
   logic [31:0]            mc_pc;
   logic                   mc_done = 1'b0;
   logic [32*BLK_WORDS-1:0] mc_data = '0;
   logic                   rob_set_pc_en = 1'b0;
   logic [31:0]            rob_set_pc = '0;
   logic                   rob_br = 1'b0;
   logic                   rob_br_jump = 1'b0;
   logic [31:0]            rob_br_pc = '0;

   exp_t        sb[$];
   exp_t        mon_e;
   int          tests = 0;
   int          fails = 0;
   int          prog = 0;
   bit          resp_hold = 1'b0;
   int          fills = 0;
   logic [31:0] last_fill = '0;

   ifetch_unit #(
      .ADDR_W(32), .WAYS(2), .SETS(16), .BLK_WORDS(BLK_WORDS),
      .BHT_ENTRIES(256), .QUEUE_DEPTH(4), .RESET_PC(32'h0)
   ) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
      .out_pc(out_pc), .out_pred_jump(out_pred_jump), .out_pred_pc(out_pred_pc),
      .mc_en(mc_en), .mc_pc(mc_pc), .mc_done(mc_done), .mc_data(mc_data),
      .rob_set_pc_en(rob_set_pc_en), .rob_set_pc(rob_set_pc),
      .rob_br(rob_br), .rob_br_jump(rob_br_jump), .rob_br_pc(rob_br_pc)
   );

   always #5 clk = ~clk;

   // program image: prog 1 places JAL +0x20 at 0x8 and BEQ -8 at 0x40
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (prog == 1 && a == 32'h8)  return 32'h020000EF;
      if (prog == 1 && a == 32'h40) return 32'hFE000CE3;
      return {a[26:2], 7'b0010011};
   endfunction

   function automatic exp_t plain(input logic [31:0] a);
      exp_t e;
      e.inst = {a[26:2], 7'b0010011};
      e.pc   = a;
      e.jump = 1'b0;
      e.ppc  = a + 32'd4;
      return e;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; out_ready = 1'b0; rob_set_pc_en = 1'b0; rob_br = 1'b0;
      resp_hold = 1'b0; sb.delete();
      tick(2);
      rst = 1'b1;
   endtask

   task automatic redirect(input logic [31:0] a);
      rob_set_pc_en = 1'b1; rob_set_pc = a;
      tick(1);
      rob_set_pc_en = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int c = 0;
      out_ready = 1'b1;
      while (sb.size() != 0 && c < budget) begin tick(1); c++; end
      out_ready = 1'b0;
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain_timeout left=%0d required=0", sb.size());
         sb.delete();
      end
   endtask

   task automatic wait_valid(input int budget);
      int c = 0;
      while (!out_valid && c < budget) begin tick(1); c++; end
      tests++;
      if (out_valid !== 1'b1) begin
         fails++;
         $display("FAIL wait_out_valid act=%b required=1", out_valid);
      end
   endtask

   // memory controller model: answers a held request after a few cycles
   initial begin
      int lat = 0;
      forever begin
         @(posedge clk); #1;
         mc_done = 1'b0;
         if (mc_en === 1'b1 && rst && rdy && !resp_hold) begin
            if (lat >= 3) begin
               for (int i = 0; i < BLK_WORDS; i++)
                  mc_data[32*i +: 32] = mem_word(mc_pc + 32'(4*i));
               mc_done = 1'b1; lat = 0; fills++; last_fill = mc_pc;
            end else lat++;
         end else lat = 0;
      end
   end

   // scoreboard: every accepted queue head is compared with the next expectation
   always @(negedge clk) begin
      if (rst && rdy && out_valid && out_ready) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_out act_pc=%h required=none", out_pc);
         end else begin
            mon_e = sb.pop_front();
            if ({out_inst, out_pc, out_pred_jump, out_pred_pc} !== mon_e) begin
               fails++;
               $display("FAIL out_entry act inst=%h pc=%h j=%b ppc=%h required inst=%h pc=%h j=%b ppc=%h",
                        out_inst, out_pc, out_pred_jump, out_pred_pc,
                        mon_e.inst, mon_e.pc, mon_e.jump, mon_e.ppc);
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b0;
      tick(2);
      tests++;
      if ({out_valid, mc_en, mc_pc} !== {1'b0, 1'b0, 32'h0}) begin
         fails++;
         $display("FAIL reset_state act valid=%b mc_en=%b mc_pc=%h required 0 0 0", out_valid, mc_en, mc_pc);
      end
   endtask

   task automatic test_cold_start();
      prog = 0;
      do_reset();
      tests++;
      if (mc_en !== 1'b0) begin fails++; $display("FAIL cold_mc_en_c0 act=%b required=0", mc_en); end
      tick(1);
      tests++;
      if ({mc_en, mc_pc} !== {1'b1, 32'h0}) begin
         fails++; $display("FAIL cold_request act mc_en=%b mc_pc=%h required 1 00000000", mc_en, mc_pc);
      end
      for (int i = 0; i < 16; i++) sb.push_back(plain(32'(4*i)));
      wait_drain(80);
   endtask

   task automatic test_stall();
      prog = 0;
      do_reset();
      wait_valid(40);
      tick(8);
      tests++;
      if ({out_valid, out_pc, mc_en} !== {1'b1, 32'h0, 1'b0}) begin
         fails++; $display("FAIL stall_hold act valid=%b pc=%h mc_en=%b required 1 00000000 0", out_valid, out_pc, mc_en);
      end
      tick(5);
      tests++;
      if (out_pc !== 32'h0) begin fails++; $display("FAIL stall_head act=%h required=00000000", out_pc); end
      for (int i = 0; i < 16; i++) sb.push_back(plain(32'(4*i)));
      wait_drain(60);
   endtask

   task automatic test_predict();
      exp_t e;
      prog = 1;
      do_reset();
      sb.push_back(plain(32'h0));
      sb.push_back(plain(32'h4));
      e.inst = 32'h020000EF; e.pc = 32'h8; e.jump = 1'b1; e.ppc = 32'h28;
      sb.push_back(e);
      for (int a = 32'h28; a <= 32'h3c; a += 4) sb.push_back(plain(32'(a)));
      e.inst = 32'hFE000CE3; e.pc = 32'h40; e.jump = 1'b0; e.ppc = 32'h44;
      sb.push_back(e);
      sb.push_back(plain(32'h44));
      wait_drain(120);
      rob_br = 1'b1; rob_br_jump = 1'b1; rob_br_pc = 32'h40;
      tick(2);
      rob_br = 1'b0;
      redirect(32'h40);
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL redirect_flush act=%b required=0", out_valid); end
      tick(1);
      tests++;
      if ({out_valid, out_pc} !== {1'b1, 32'h40}) begin
         fails++; $display("FAIL redirect_first act valid=%b pc=%h required 1 00000040", out_valid, out_pc);
      end
      e.inst = 32'hFE000CE3; e.pc = 32'h40; e.jump = 1'b1; e.ppc = 32'h38;
      sb.push_back(e);
      sb.push_back(plain(32'h38));
      sb.push_back(plain(32'h3c));
      sb.push_back(e);
      sb.push_back(plain(32'h38));
      wait_drain(40);
      prog = 0;
   endtask

   task automatic test_redirect_fill();
      int f0;
      int c = 0;
      prog = 0;
      do_reset();
      wait_valid(40);
      f0 = fills;
      resp_hold = 1'b1;
      redirect(32'h40);
      while (!mc_en && c < 20) begin tick(1); c++; end
      tick(1);
      redirect(32'h0);
      tests++;
      if ({mc_en, mc_pc} !== {1'b1, 32'h40}) begin
         fails++; $display("FAIL fill_pending act mc_en=%b mc_pc=%h required 1 00000040", mc_en, mc_pc);
      end
      for (int i = 0; i < 16; i++) sb.push_back(plain(32'(4*i)));
      wait_drain(60);
      tests++;
      if ({mc_en, mc_pc} !== {1'b1, 32'h40} || fills != f0) begin
         fails++; $display("FAIL fill_held act mc_en=%b mc_pc=%h fills=%0d required 1 00000040 %0d", mc_en, mc_pc, fills, f0);
      end
      resp_hold = 1'b0;
      for (int i = 0; i < 4; i++) sb.push_back(plain(32'(32'h40 + 4*i)));
      wait_drain(60);
      tests++;
      if (fills != f0 + 1 || last_fill !== 32'h40) begin
         fails++; $display("FAIL fill_once act fills=%0d addr=%h required %0d 00000040", fills, last_fill, f0 + 1);
      end
      redirect(32'h40);
      wait_valid(20);
      tests++;
      if (out_pc !== 32'h40 || fills != f0 + 1 || mc_en !== 1'b0) begin
         fails++; $display("FAIL refetch_hit act pc=%h fills=%0d mc_en=%b required 00000040 %0d 0", out_pc, fills, mc_en, f0 + 1);
      end
   endtask

   task automatic test_replace();
      logic [31:0] addrs [7];
      int          incs  [7];
      int          f;
      addrs = '{32'h400, 32'h800, 32'hC00, 32'h800, 32'hC00, 32'h000, 32'h400};
      incs  = '{1, 1, 1, 0, 0, 1, 1};
      prog = 0;
      do_reset();
      wait_valid(40);
      f = fills;
      for (int k = 0; k < 7; k++) begin
         redirect(addrs[k]);
         wait_valid(40);
         f += incs[k];
         tests++;
         if (out_pc !== addrs[k] || fills != f) begin
            fails++; $display("FAIL replace_step%0d act pc=%h fills=%0d required %h %0d", k, out_pc, fills, addrs[k], f);
         end
      end
   endtask

   task automatic test_reset_midfill();
      int c = 0;
      prog = 0;
      do_reset();
      wait_valid(40);
      resp_hold = 1'b1;
      redirect(32'h30);
      while (!mc_en && c < 20) begin tick(1); c++; end
      tick(2);
      tests++;
      if ({out_valid, out_pc, mc_en, mc_pc} !== {1'b1, 32'h30, 1'b1, 32'h40}) begin
         fails++; $display("FAIL midfill_setup act valid=%b pc=%h mc_en=%b mc_pc=%h required 1 00000030 1 00000040",
                           out_valid, out_pc, mc_en, mc_pc);
      end
      rst = 1'b0;
      tick(1);
      tests++;
      if ({out_valid, mc_en} !== 2'b00) begin
         fails++; $display("FAIL midfill_reset act valid=%b mc_en=%b required 0 0", out_valid, mc_en);
      end
      rst = 1'b1;
      tick(1);
      tests++;
      if ({mc_en, mc_pc} !== {1'b1, 32'h0}) begin
         fails++; $display("FAIL lines_invalid act mc_en=%b mc_pc=%h required 1 00000000", mc_en, mc_pc);
      end
      resp_hold = 1'b0;
      wait_valid(40);
      tests++;
      if (out_pc !== 32'h0) begin fails++; $display("FAIL post_reset_head act=%h required=00000000", out_pc); end
   endtask

   initial begin
      #1;
      test_reset();
      test_cold_start();
      test_stall();
      test_predict();
      test_redirect_fill();
      test_replace();
      test_reset_midfill();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog act=timeout required=finish");
      $fatal(1);
   end

endmodule
